// File: rtl/btn_debounce_ctrl.sv
// Pushbutton debouncer: two-flop synchronizer, free-running sample tick and a
// qualify FSM that accepts a level change only after STABLE_TICKS stable ticks.
module btn_debounce_ctrl #(
   parameter int TICK_COUNT   = 100000,
   parameter int STABLE_TICKS = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic D,
   output logic db_level,
   output logic ped,
   output logic ned,
   output logic busy
);

   localparam int TW = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
   localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TICK_COUNT - 1);
   localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);

   typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

   state_t          state, state_n;
   logic            s1, s_in;
   logic [TW-1:0]   tcnt;
   logic            tick;
   logic [CW-1:0]   cnt, cnt_n;

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1   <= 1'b0;
         s_in <= 1'b0;
      end else begin
         s1   <= D;
         s_in <= s1;
      end
   end

   // Tick phase is independent of the FSM so qualification time depends only
   // on where in the tick period the input settles.
   assign tick = (tcnt == TMAX);

   always_ff @(posedge clk) begin
      if (!reset)    tcnt <= '0;
      else if (tick) tcnt <= '0;
      else           tcnt <= tcnt + TW'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ZERO;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         ZERO: begin
            if (s_in) begin
               state_n = WAIT1;
               cnt_n   = '0;
            end
         end
         WAIT1: begin
            if (!s_in) state_n = ZERO;
            else if (tick) begin
               if (cnt == CMAX) state_n = ONE;
               else             cnt_n   = cnt + CW'(1);
            end
         end
         ONE: begin
            if (!s_in) begin
               state_n = WAIT0;
               cnt_n   = '0;
            end
         end
         WAIT0: begin
            if (s_in) state_n = ONE;
            else if (tick) begin
               if (cnt == CMAX) state_n = ZERO;
               else             cnt_n   = cnt + CW'(1);
            end
         end
         default: state_n = ZERO;
      endcase
   end

   // Outputs trail the state by one register; comparing the new level with
   // the previous db_level yields the one-cycle edge pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         db_level <= 1'b0;
         ped      <= 1'b0;
         ned      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         db_level <= (state == ONE) || (state == WAIT0);
         ped      <= (state == ONE) && !db_level;
         ned      <= (state == ZERO) && db_level;
         busy     <= (state == WAIT1) || (state == WAIT0);
      end
   end

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Randomized and directed bench for btn_debounce_ctrl against a tick-counting
// reference model of the debounce acceptance rule.
module tb_btn_debounce_ctrl;

   localparam int T = 4;
   localparam int S = 3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic D = 1'b0;
   logic db_level, ped, ned, busy;

   btn_debounce_ctrl #(.TICK_COUNT(T), .STABLE_TICKS(S)) dut (
      .clk(clk), .reset(reset), .D(D),
      .db_level(db_level), .ped(ped), .ned(ned), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // reference model state
   logic m_s1 = 0, m_sin = 0, m_lvl = 0, m_wait = 0;
   int   m_tc = 0, m_ticks = 0;
   logic o_db = 0, o_ped = 0, o_ned = 0, o_busy = 0;

   int cyc = 0, e0 = 0, ped_n = 0, ned_n = 0, last_ped = 0, last_ned = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input logic d, input logic r);
      logic tk, lvl_old, wait_old;
      @(negedge clk);
      D = d;
      reset = r;
      @(posedge clk);
      if (!r) begin
         m_s1 = 0; m_sin = 0; m_lvl = 0; m_wait = 0; m_tc = 0; m_ticks = 0;
         o_db = 0; o_ped = 0; o_ned = 0; o_busy = 0;
      end else begin
         tk = (m_tc == T - 1);
         lvl_old = m_lvl;
         wait_old = m_wait;
         // a change is accepted on the S-th tick seen while the synchronized
         // input has disagreed continuously since the edge that noticed it
         if (m_sin != m_lvl) begin
            if (!m_wait) begin
               m_wait = 1;
               m_ticks = 0;
            end else if (tk) begin
               m_ticks++;
               if (m_ticks == S) begin
                  m_lvl = m_sin;
                  m_wait = 0;
               end
            end
         end else m_wait = 0;
         o_ped = lvl_old & ~o_db;
         o_ned = ~lvl_old & o_db;
         o_db = lvl_old;
         o_busy = wait_old;
         m_sin = m_s1;
         m_s1 = d;
         m_tc = tk ? 0 : m_tc + 1;
      end
      #1;
      cyc++;
      chk("db_level", db_level, o_db);
      chk("ped", ped, o_ped);
      chk("ned", ned, o_ned);
      chk("busy", busy, o_busy);
      if (ped === 1'b1) begin ped_n++; last_ped = cyc; end
      if (ned === 1'b1) begin ned_n++; last_ned = cyc; end
   endtask

   initial begin
      int guard;
      logic d, r;

      // reset held with D high: outputs zero, then treated as a new press
      for (int i = 0; i < 3; i++) begin
         step(1, 0);
         chk("rst_outs", {db_level, ped, ned, busy}, 0);
      end
      ped_n = 0;
      e0 = cyc + 1;
      repeat (30) step(1, 1);
      chk("rst_ped_cnt", ped_n, 1);
      chk("rst_ped_lat", (last_ped - e0 >= 12) && (last_ped - e0 <= 15), 1);
      chk("rst_db_hold", db_level, 1);

      // release
      ped_n = 0; ned_n = 0;
      e0 = cyc + 1;
      repeat (30) step(0, 1);
      chk("rel_ned_cnt", ned_n, 1);
      chk("rel_ped_cnt", ped_n, 0);
      chk("rel_ned_lat", (last_ned - e0 >= 12) && (last_ned - e0 <= 15), 1);
      chk("rel_db", db_level, 0);

      // clean presses at random tick phases
      for (int p = 0; p < 4; p++) begin
         repeat ($urandom_range(0, 7)) step(0, 1);
         ped_n = 0;
         e0 = cyc + 1;
         repeat (4) step(1, 1);
         chk("press_busy3", busy, 1);
         repeat (36) step(1, 1);
         chk("press_ped_cnt", ped_n, 1);
         chk("press_ped_lat", (last_ped - e0 >= 12) && (last_ped - e0 <= 15), 1);
         chk("press_db", db_level, 1);
         chk("press_busy_lo", busy, 0);
         repeat (30) step(0, 1);
      end

      // bounce rejection
      ped_n = 0; ned_n = 0;
      for (int i = 0; i < 10; i++) repeat (3) step(((i % 2) == 0), 1);
      repeat (20) step(0, 1);
      chk("bnc_ped_cnt", ped_n, 0);
      chk("bnc_ned_cnt", ned_n, 0);
      chk("bnc_db", db_level, 0);
      chk("bnc_busy", busy, 0);

      // bounce arriving on the same edge as the final qualifying tick
      ped_n = 0;
      guard = 0;
      while (!(m_wait && m_ticks == S - 1) && guard < 50) begin
         step(1, 1);
         guard++;
      end
      chk("bt_reach", guard < 50, 1);
      step(1, 1);
      step(0, 1);
      repeat (20) step(0, 1);
      chk("bt_ped_cnt", ped_n, 0);
      chk("bt_db", db_level, 0);
      e0 = cyc + 1;
      repeat (30) step(1, 1);
      chk("bt_next_ped_cnt", ped_n, 1);
      chk("bt_next_lat", (last_ped - e0 >= 12) && (last_ped - e0 <= 15), 1);
      repeat (30) step(0, 1);

      // reset during qualification
      ped_n = 0;
      repeat (5) step(1, 1);
      chk("rq_busy", busy, 1);
      step(0, 0);
      chk("rq_outs", {db_level, ped, ned, busy}, 0);
      repeat (30) step(0, 1);
      chk("rq_ped_cnt", ped_n, 0);
      chk("rq_db", db_level, 0);

      // random runs with occasional resets
      for (int i = 0; i < 200; i++) begin
         d = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 30) == 0) ? 1'b0 : 1'b1;
         step(d, r);
         repeat ($urandom_range(0, 24)) step(d, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
